// File: rtl/unified_mem_arbiter.sv
// Arbitrates the fetch and data ports onto one variable-latency backing memory,
// with fetch starvation protection and a watchdog that aborts hung accesses.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            owner_if;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   wait_cnt;
    logic            grant_if;
    logic            timed_out;
    logic [DATA_W-1:0] resp_data;

    // Fetch wins only when alone or when data has had its full run of grants.
    assign grant_if  = if_req & (~dm_req | (starve_cnt == SW'(STARVE_LIMIT)));
    assign timed_out = (wait_cnt == TW'(TIMEOUT - 1));
    assign resp_data = mem_ready ? mem_rdata : '0;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner_if   <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req | dm_req) begin
                        owner_if  <= grant_if;
                        mem_req   <= 1'b1;
                        mem_addr  <= grant_if ? if_addr : dm_addr;
                        mem_we    <= ~grant_if & dm_we;
                        mem_wdata <= grant_if ? '0 : dm_wdata;
                        wait_cnt  <= '0;
                        if (~grant_if & if_req) begin
                            if (starve_cnt != SW'(STARVE_LIMIT)) begin
                                starve_cnt <= starve_cnt + SW'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A ready in the timeout cycle still completes normally.
                    if (mem_ready | timed_out) begin
                        mem_req <= 1'b0;
                        err     <= ~mem_ready;
                        if (owner_if) begin
                            if_rdata <= resp_data;
                            if_ack   <= 1'b1;
                        end else begin
                            dm_rdata <= resp_data;
                            dm_ack   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    err    <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a transaction-level model predicts
// every output each cycle; directed tests pin latencies, data and grant order.
module tb_unified_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready;
    logic        err;
    logic        stall_if;
    logic        stall_mem;

    logic        mdl_ready = 1'b0;
    logic        inj_ready = 1'b0;
    int          mdelay = 0;
    int          mcnt = 0;
    logic [31:0] tbmem [logic [31:0]];

    int compared = 0;
    int mismatched = 0;
    bit checking = 1'b0;

    assign mem_ready = mdl_ready | inj_ready;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: answers mdelay cycles into each access (-1 = never).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mdl_ready = 1'b0;
            if (mem_req === 1'b1 && !reset) begin
                if (mcnt == mdelay) begin
                    mdl_ready = 1'b1;
                    if (mem_we) tbmem[mem_addr] = mem_wdata;
                    mem_rdata = tbmem.exists(mem_addr) ? tbmem[mem_addr] : 32'd0;
                end
                mcnt++;
            end else begin
                mcnt = 0;
            end
        end
    end

    // Transaction model: one access in flight, tracked by owner, age and phase.
    logic        e_busy, e_resp, e_owner_if, e_we, e_if_ack, e_dm_ack, e_err;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;
    int          e_age, e_streak;
    bit          pick_if;

    always @(posedge clk) begin
        if (reset) begin
            e_busy <= 1'b0; e_resp <= 1'b0; e_owner_if <= 1'b0; e_we <= 1'b0;
            e_if_ack <= 1'b0; e_dm_ack <= 1'b0; e_err <= 1'b0;
            e_addr <= 32'd0; e_wdata <= 32'd0; e_if_rdata <= 32'd0; e_dm_rdata <= 32'd0;
            e_age <= 0; e_streak <= 0;
        end else if (e_resp) begin
            e_resp <= 1'b0; e_if_ack <= 1'b0; e_dm_ack <= 1'b0; e_err <= 1'b0;
        end else if (e_busy) begin
            if (mem_ready || e_age == TIMEOUT - 1) begin
                e_busy <= 1'b0;
                e_resp <= 1'b1;
                e_err  <= !mem_ready;
                if (e_owner_if) begin
                    e_if_ack <= 1'b1; e_if_rdata <= mem_ready ? mem_rdata : 32'd0;
                end else begin
                    e_dm_ack <= 1'b1; e_dm_rdata <= mem_ready ? mem_rdata : 32'd0;
                end
            end else begin
                e_age <= e_age + 1;
            end
        end else if (if_req || dm_req) begin
            pick_if = if_req && (!dm_req || e_streak == STARVE_LIMIT);
            e_busy     <= 1'b1;
            e_age      <= 0;
            e_owner_if <= pick_if;
            e_addr     <= pick_if ? if_addr : dm_addr;
            e_we       <= pick_if ? 1'b0 : dm_we;
            e_wdata    <= pick_if ? 32'd0 : dm_wdata;
            e_streak   <= (!pick_if && if_req) ? ((e_streak < STARVE_LIMIT) ? e_streak + 1 : e_streak) : 0;
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("if_ack", {31'd0, if_ack}, {31'd0, e_if_ack});
            chk("dm_ack", {31'd0, dm_ack}, {31'd0, e_dm_ack});
            chk("err", {31'd0, err}, {31'd0, e_err});
            chk("mem_req", {31'd0, mem_req}, {31'd0, e_busy});
            chk("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~e_if_ack});
            chk("stall_mem", {31'd0, stall_mem}, {31'd0, dm_req & ~e_dm_ack});
            if (e_if_ack) chk("if_rdata", if_rdata, e_if_rdata);
            if (e_dm_ack) chk("dm_rdata", dm_rdata, e_dm_rdata);
            if (e_busy) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
                chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    // One access on one port; lat counts edges from request to visible ack.
    task automatic access(input bit is_if, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                          output int lat, output logic [31:0] cap_addr, output logic cap_we,
                          output logic [31:0] cap_wdata);
        bit got;
        @(posedge clk); #1;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end
        lat = 0; got = 1'b0;
        cap_addr = 32'd0; cap_we = 1'b0; cap_wdata = 32'd0;
        while (!got && lat < 200) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (lat == 1) begin
                cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
            end
            got = is_if ? if_ack : dm_ack;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        rd = is_if ? if_rdata : dm_rdata;
        er = err;
        @(posedge clk); #1;
        if (is_if) if_req = 1'b0; else dm_req = 1'b0;
    endtask

    logic [31:0] rd, ca, cw;
    logic        er, cwe;
    int          lat;
    bit          order[$];
    bit          exp_order[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        tbmem[32'h10] = 32'hDEADBEEF;
        tbmem[32'h40] = 32'hA5A5A5A5;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);

        // Single fetch, memory answers two cycles after mem_req rises.
        mdelay = 2;
        access(1'b1, 1'b0, 32'h10, 32'd0, rd, er, lat, ca, cwe, cw);
        chk("fetch_rdata", rd, 32'hDEADBEEF);
        chk("fetch_lat", lat, 32'd4);
        chk("fetch_addr", ca, 32'h10);
        chk("fetch_we", {31'd0, cwe}, 32'd0);
        @(negedge clk);
        chk("fetch_stall_after", {31'd0, stall_if}, 32'd0);

        // Store then load, zero-wait memory.
        mdelay = 0;
        access(1'b0, 1'b1, 32'h20, 32'h1234, rd, er, lat, ca, cwe, cw);
        chk("store_we", {31'd0, cwe}, 32'd1);
        chk("store_wdata", cw, 32'h1234);
        chk("store_lat", lat, 32'd2);
        access(1'b0, 1'b0, 32'h20, 32'd0, rd, er, lat, ca, cwe, cw);
        chk("load_rdata", rd, 32'h1234);

        // Contention: both held, grants must follow the starvation pattern.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        for (int c = 0; c < 100 && order.size() < 10; c++) begin
            @(negedge clk);
            if (if_ack && dm_ack) chk("dual_ack", 32'd1, 32'd0);
            if (if_ack) order.push_back(1'b1);
            else if (dm_ack) order.push_back(1'b0);
        end
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
        chk("order_len", order.size(), 32'd10);
        for (int i = 0; i < 10 && i < order.size(); i++) begin
            chk($sformatf("grant_%0d", i), {31'd0, order[i]}, {31'd0, exp_order[i]});
        end

        // Timeout: memory never answers.
        mdelay = -1;
        access(1'b0, 1'b0, 32'h30, 32'd0, rd, er, lat, ca, cwe, cw);
        chk("to_lat", lat, 32'd65);
        chk("to_err", {31'd0, er}, 32'd1);
        chk("to_rdata", rd, 32'd0);
        mdelay = 1;
        access(1'b1, 1'b0, 32'h10, 32'd0, rd, er, lat, ca, cwe, cw);
        chk("post_to_rdata", rd, 32'hDEADBEEF);
        chk("post_to_err", {31'd0, er}, 32'd0);

        // Ready lands exactly in the timeout cycle.
        mdelay = TIMEOUT - 1;
        access(1'b0, 1'b0, 32'h40, 32'd0, rd, er, lat, ca, cwe, cw);
        chk("edge_lat", lat, 32'd65);
        chk("edge_err", {31'd0, er}, 32'd0);
        chk("edge_rdata", rd, 32'hA5A5A5A5);

        // Reset in the second WAIT cycle, then a stray ready.
        mdelay = -1;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'h55;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1; dm_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mr_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mr_acks", {29'd0, if_ack, dm_ack, err}, 32'd0);
        chk("mr_mem_bus", mem_addr | mem_wdata | {31'd0, mem_we}, 32'd0);
        chk("mr_rdata", if_rdata | dm_rdata, 32'd0);
        @(posedge clk); #1; inj_ready = 1'b1;
        @(posedge clk); #1; inj_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_no_ack", {30'd0, if_ack, dm_ack}, 32'd0);
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported backing memory between the pipeline's instruction-fetch port and its MEM-stage data port. The block sits between the processor top level (PC/instruction fetch and data load/store) and a unified memory with a variable-latency ready handshake. It serialises the accesses, returns read data to the requester that owns the access, and produces stall requests for the hazard logic. A starvation counter guarantees fetch progress, and a watchdog aborts hung accesses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (≥1)
- TIMEOUT, 64, max cycles in WAIT before abort (≥2)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse, fetch port
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ack
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse, data port
- mem_req  out  1  backing-memory request
- mem_we  out  1  backing-memory write enable
- mem_addr  out  ADDR_W  backing-memory address
- mem_wdata  out  DATA_W  backing-memory write data
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion from memory
- err  out  1  one-cycle pulse, coincident with an ack for a timed-out access
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  dm_req & ~dm_ack (combinational)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: arbitrate on the sampled requests.
  - Only one request pending: grant it.
  - Both pending: grant DM, unless starve_cnt == STARVE_LIMIT, in which case grant IF.
  - On a grant: latch owner, address, we (forced 0 for IF) and wdata into registers, then go to WAIT.
  - No request pending: stay in IDLE.
- starve_cnt update, evaluated at each grant:
  - DM granted while if_req=1: increment, saturating at STARVE_LIMIT.
  - IF granted, or if_req=0: clear to 0.
- WAIT:
  - mem_req=1; mem_we/mem_addr/mem_wdata are driven from the latched registers and stay stable for the whole state.
  - On mem_ready: capture mem_rdata into the owner's rdata register, go to RESP.
  - wait_cnt counts cycles spent in WAIT. When it reaches TIMEOUT-1 with no mem_ready: set rdata to 0, set the err flag, go to RESP.
- RESP:
  - Owner's ack=1, and err=1 if the access timed out.
  - All requests are ignored this cycle. The owner must drop req or present a new request from the next cycle.
  - Next state is always IDLE.
- Loads and stores share the same path. Store completion is the memory's mem_ready; dm_rdata is don't-care on stores (drive the captured mem_rdata).
- mem_ready outside WAIT is ignored.

## Timing
- All outputs except stall_if/stall_mem are registered.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, err=0, starve_cnt=0, wait_cnt=0.
- Minimum latency: request seen in IDLE at cycle N → mem_req high at N+1 → mem_ready earliest at N+1 → ack at N+2. Best-case throughput is one access per 3 cycles.
- Reset asserted mid-access (WAIT or RESP) takes effect at the next edge:
  - mem_req drops and no ack is issued.
  - The in-flight memory transaction is abandoned.
- Simultaneous if_req and dm_req in IDLE resolve per the starvation rule. The loser's stall stays high.
- mem_ready and the timeout condition in the same cycle: mem_ready wins, err=0.
- Requester changes address while req is held: protocol violation; the latched address is used.

## Test plan
- Single fetch: if_req=1, if_addr=0x10, memory readies 2 cycles after mem_req with 0xDEADBEEF → mem_addr=0x10, mem_we=0; if_ack pulses once with if_rdata=0xDEADBEEF; stall_if low the cycle after.
- Store then load: dm store 0x20 ← 0x1234, then dm load 0x20 → first access has mem_we=1 and mem_wdata=0x1234; the load returns dm_rdata=0x1234 with dm_ack pulse.
- Contention: if_req and dm_req held continuously, STARVE_LIMIT=4, zero-wait memory → grant order DM,DM,DM,DM,IF, repeating; no ack is ever issued to the port that is not the owner.
- Timeout: dm_req with mem_ready never asserted, TIMEOUT=64 → after exactly 64 WAIT cycles, dm_ack=1, err=1, dm_rdata=0; FSM returns to IDLE and serves a subsequent fetch normally.
- Reset mid-access: assert reset in the 2nd WAIT cycle → next cycle all outputs at reset values; a mem_ready arriving afterwards produces no ack.
- Boundary: mem_ready and the timeout condition coincide with mem_rdata=0xA5A5A5A5 → ack with err=0 and rdata=0xA5A5A5A5.
